// File: rtl/sr_frame_rx.sv
// sr_frame_rx - parametrised serial receive frame shift register.
//
// Collects one frame (data bits, optional parity bit, one or two stop bits)
// from serial_in on each shift_strobe pulse. Once the frame is complete it
// checks parity and framing and hands the data word to the consumer through
// a valid/read handshake. A word that is replaced before it was read raises
// a sticky overrun flag.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   frame_start   in   pulse: start (or restart) a frame
//   shift_strobe  in   pulse: sample serial_in
//   serial_in     in   serial data bit
//   data_read     in   consumer acknowledge of packet_data
//   packet_data   out  last completed data word (DATA_BITS wide)
//   data_valid    out  a word is waiting in packet_data
//   parity_error  out  parity mismatch on the held word
//   framing_error out  a stop bit of the held word was 0
//   overrun_error out  sticky: a word was overwritten unread
//   busy          out  receiver is not idle
module sr_frame_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int STOP_LSB   = DATA_BITS + PARITY_EN;

  localparam logic [CNT_W-1:0] CNT_LAST_STROBE = CNT_W'(FRAME_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [DATA_BITS-1:0]  load_word;
  logic                  load_parity_error;
  logic                  load_framing_error;

  // Parity mismatch of a data word plus its received parity bit.
  function automatic logic calc_parity_error(input logic [DATA_BITS-1:0] data,
                                             input logic                 pbit);
    calc_parity_error = ((^data) ^ pbit) != (PARITY_ODD != 0);
  endfunction

  // Next-state decode; frame_start always (re)enters SHIFT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (frame_start) next_state = SHIFT;
        else             next_state = IDLE;
      end
      SHIFT: begin
        if (frame_start)                                    next_state = SHIFT;
        else if (shift_strobe && (cnt == CNT_LAST_STROBE))  next_state = LOAD;
        else                                                next_state = SHIFT;
      end
      LOAD: begin
        if (frame_start) next_state = SHIFT;
        else             next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Word assembly and frame checks from the completed shift register.
  always_comb begin
    load_word = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      // First received bit sits at sr[0]; MSB-first frames are mirrored.
      if (LSB_FIRST != 0) load_word[i] = sr[i];
      else                load_word[i] = sr[DATA_BITS-1-i];
    end
    if (PARITY_EN != 0) load_parity_error = calc_parity_error(sr[DATA_BITS-1:0], sr[DATA_BITS]);
    else                load_parity_error = 1'b0;
    load_framing_error = ~(&sr[FRAME_BITS-1:STOP_LSB]);
  end

  // State register and busy flag (busy follows the state being entered).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // Bit counter and shift register; new bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            cnt <= '0;
            sr  <= '0;
          end else begin
            cnt <= cnt;
            sr  <= sr;
          end
        end
        SHIFT: begin
          // frame_start wins over a coincident strobe
          if (frame_start) begin
            cnt <= '0;
            sr  <= '0;
          end else if (shift_strobe) begin
            cnt <= cnt + CNT_W'(1);
            sr  <= {serial_in, sr[FRAME_BITS-1:1]};
          end else begin
            cnt <= cnt;
            sr  <= sr;
          end
        end
        LOAD: begin
          // Leaves for IDLE or a fresh frame; both start from a clean register.
          cnt <= '0;
          sr  <= '0;
        end
        default: begin
          cnt <= '0;
          sr  <= '0;
        end
      endcase
    end
  end

  // Output word, status flags and the valid/read/overrun handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_data   <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (state == LOAD) begin
      packet_data   <= load_word;
      parity_error  <= load_parity_error;
      framing_error <= load_framing_error;
      data_valid    <= 1'b1;
      // A read in the load cycle acknowledges the old word: no overrun,
      // and any earlier overrun is cleared.
      if (data_read)       overrun_error <= 1'b0;
      else if (data_valid) overrun_error <= 1'b1;
      else                 overrun_error <= overrun_error;
    end else if (data_valid && data_read) begin
      data_valid    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      data_valid    <= data_valid;
      overrun_error <= overrun_error;
    end
  end

endmodule

// File: tb/tb_sr_frame_rx.sv
// tb_sr_frame_rx - self-checking bench for sr_frame_rx.
//
// Three instances cover the configuration space used here:
//   0: defaults (8 data, no parity, 1 stop, LSB first)
//   1: 8 data, even parity, 2 stop bits, LSB first
//   2: 8 data, odd parity, 1 stop bit, MSB first
// Expected outputs come from a transaction-level model: the word that was
// sent, parity from a popcount, framing from the stop bits, and a
// valid/overrun pair updated per delivered word and per read.
module tb_sr_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       fs [3];
  logic       st [3];
  logic       si [3];
  logic       rd [3];
  logic [7:0] pd [3];
  logic       v  [3];
  logic       pe_o [3];
  logic       fe [3];
  logic       ov [3];
  logic       bz [3];

  int c_pe  [3] = '{0, 1, 1};
  int c_po  [3] = '{0, 0, 1};
  int c_sb  [3] = '{1, 2, 1};
  int c_lsb [3] = '{1, 1, 0};

  logic [7:0] m_pd [3];
  logic       m_v  [3];
  logic       m_pe [3];
  logic       m_fe [3];
  logic       m_ov [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_frame_rx u_dut0 (
    .clk(clk), .rst(rst), .frame_start(fs[0]), .shift_strobe(st[0]),
    .serial_in(si[0]), .data_read(rd[0]), .packet_data(pd[0]),
    .data_valid(v[0]), .parity_error(pe_o[0]), .framing_error(fe[0]),
    .overrun_error(ov[0]), .busy(bz[0])
  );

  sr_frame_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .LSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_start(fs[1]), .shift_strobe(st[1]),
    .serial_in(si[1]), .data_read(rd[1]), .packet_data(pd[1]),
    .data_valid(v[1]), .parity_error(pe_o[1]), .framing_error(fe[1]),
    .overrun_error(ov[1]), .busy(bz[1])
  );

  sr_frame_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .frame_start(fs[2]), .shift_strobe(st[2]),
    .serial_in(si[2]), .data_read(rd[2]), .packet_data(pd[2]),
    .data_valid(v[2]), .parity_error(pe_o[2]), .framing_error(fe[2]),
    .overrun_error(ov[2]), .busy(bz[2])
  );

  // ---------------- value packers (observed / expected) ----------------
  function automatic logic [12:0] obs_vec(int k);
    return {pd[k], v[k], pe_o[k], fe[k], ov[k], bz[k]};
  endfunction

  function automatic logic [12:0] exp_vec(int k, logic busy_exp);
    return {m_pd[k], m_v[k], m_pe[k], m_fe[k], m_ov[k], busy_exp};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pd[k] = 8'h00; m_v[k] = 1'b0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; m_ov[k] = 1'b0;
    end
  endtask

  task automatic model_load(int k, logic [7:0] data, logic pbit, logic [1:0] stops, logic rd_at_load);
    int ones;
    ones = $countones(data) + int'(pbit);
    m_pd[k] = data;
    m_pe[k] = (c_pe[k] != 0) ? ((ones % 2) != c_po[k]) : 1'b0;
    m_fe[k] = (c_sb[k] == 2) ? (stops != 2'b11) : (stops[0] == 1'b0);
    if (rd_at_load)  m_ov[k] = 1'b0;
    else if (m_v[k]) m_ov[k] = 1'b1;
    m_v[k] = 1'b1;
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic start(int k);
    @(negedge clk); fs[k] = 1'b1;
    @(negedge clk); fs[k] = 1'b0;
  endtask

  task automatic strobe(int k, logic b);
    @(negedge clk); st[k] = 1'b1; si[k] = b;
    @(negedge clk); st[k] = 1'b0;
  endtask

  // Sends one full frame; returns at the sampling point after the load edge.
  task automatic send_frame(int k, logic with_start, logic [7:0] data, logic pbit,
                            logic [1:0] stops, logic rd_at_load);
    if (with_start) start(k);
    for (int i = 0; i < 8; i++) strobe(k, (c_lsb[k] != 0) ? data[i] : data[7-i]);
    if (c_pe[k] != 0) strobe(k, pbit);
    strobe(k, stops[0]);
    if (c_sb[k] == 2) strobe(k, stops[1]);
    rd[k] = rd_at_load;          // now inside the LOAD cycle
    @(negedge clk); rd[k] = 1'b0;
    model_load(k, data, pbit, stops, rd_at_load);
  endtask

  task automatic do_read(int k);
    @(negedge clk); rd[k] = 1'b1;
    @(negedge clk); rd[k] = 1'b0;
    if (m_v[k]) begin
      m_v[k]  = 1'b0;
      m_ov[k] = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== 13'h0000) begin
        errors++;
        $display("FAIL reset inst%0d: got %h expected %h", k, obs_vec(k), 13'h0000);
      end
    end
  endtask

  task automatic test_defaults();
    send_frame(0, 1'b1, 8'hA5, 1'b0, 2'b11, 1'b0);
    checks++;
    if (obs_vec(0) !== {8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL default_a5: got %h expected %h", obs_vec(0), {8'hA5, 5'b10000});
    end
    do_read(0);
    checks++;
    if (obs_vec(0) !== exp_vec(0, 1'b0)) begin
      errors++;
      $display("FAIL default_read: got %h expected %h", obs_vec(0), exp_vec(0, 1'b0));
    end
    send_frame(0, 1'b1, 8'hA5, 1'b0, 2'b10, 1'b0);
    checks++;
    if (obs_vec(0) !== {8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL default_framing: got %h expected %h", obs_vec(0), {8'hA5, 5'b10100});
    end
    do_read(0);
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic       p;
    logic [1:0] s;
    for (int t = 0; t < 4; t++) begin
      d = 8'h07;
      p = (t == 1) ? 1'b1 : 1'b0;
      s = (t == 3) ? 2'b01 : 2'b11;
      send_frame((t == 2) ? 2 : 1, 1'b1, d, p, s, 1'b0);
      checks++;
      if (obs_vec((t == 2) ? 2 : 1) !== exp_vec((t == 2) ? 2 : 1, 1'b0)) begin
        errors++;
        $display("FAIL parity_case%0d: got %h expected %h", t,
                 obs_vec((t == 2) ? 2 : 1), exp_vec((t == 2) ? 2 : 1, 1'b0));
      end
      do_read((t == 2) ? 2 : 1);
    end
    // Absolute expectations from the plan: even/p0 err, even/p1 ok, odd/p0 ok
    send_frame(1, 1'b1, 8'h07, 1'b0, 2'b11, 1'b0);
    checks++;
    if (pe_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL parity_even_p0: got %b expected 1", pe_o[1]);
    end
    do_read(1);
    send_frame(2, 1'b1, 8'h07, 1'b0, 2'b11, 1'b0);
    checks++;
    if (pe_o[2] !== 1'b0 || pd[2] !== 8'h07) begin
      errors++;
      $display("FAIL parity_odd_p0: got %b/%h expected 0/07", pe_o[2], pd[2]);
    end
    do_read(2);
  endtask

  task automatic test_overrun();
    send_frame(0, 1'b1, 8'h11, 1'b0, 2'b11, 1'b0);
    send_frame(0, 1'b1, 8'h22, 1'b0, 2'b11, 1'b0);
    checks++;
    if (obs_vec(0) !== {8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL overrun_set: got %h expected %h", obs_vec(0), {8'h22, 5'b10010});
    end
    do_read(0);
    checks++;
    if (v[0] !== 1'b0 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got v=%b ov=%b expected v=0 ov=0", v[0], ov[0]);
    end
    send_frame(0, 1'b1, 8'h33, 1'b0, 2'b11, 1'b0);
    send_frame(0, 1'b1, 8'h44, 1'b0, 2'b11, 1'b0);
    send_frame(0, 1'b1, 8'h55, 1'b0, 2'b11, 1'b1);
    checks++;
    if (obs_vec(0) !== {8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_at_load: got %h expected %h", obs_vec(0), {8'h55, 5'b10000});
    end
    do_read(0);
    // A read with nothing pending changes nothing.
    do_read(0);
    checks++;
    if (obs_vec(0) !== exp_vec(0, 1'b0)) begin
      errors++;
      $display("FAIL idle_read: got %h expected %h", obs_vec(0), exp_vec(0, 1'b0));
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k += 2) begin
      start(k);
      for (int i = 0; i < 4; i++) strobe(k, 1'b1);
      checks++;
      if (obs_vec(k) !== exp_vec(k, 1'b1)) begin
        errors++;
        $display("FAIL abort_partial inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k, 1'b1));
      end
      send_frame(k, 1'b1, 8'h3C, 1'b0, 2'b11, 1'b0);
      checks++;
      if (obs_vec(k) !== exp_vec(k, 1'b0) || pd[k] !== 8'h3C) begin
        errors++;
        $display("FAIL abort_3c inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k, 1'b0));
      end
      do_read(k);
    end
    // frame_start coinciding with a strobe: the strobe is dropped.
    start(0);
    for (int i = 0; i < 3; i++) strobe(0, 1'b0);
    @(negedge clk); fs[0] = 1'b1; st[0] = 1'b1; si[0] = 1'b0;
    @(negedge clk); fs[0] = 1'b0; st[0] = 1'b0;
    send_frame(0, 1'b0, 8'hC3, 1'b0, 2'b11, 1'b0);
    checks++;
    if (obs_vec(0) !== exp_vec(0, 1'b0)) begin
      errors++;
      $display("FAIL abort_with_strobe: got %h expected %h", obs_vec(0), exp_vec(0, 1'b0));
    end
    do_read(0);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(1, 1'b1, 8'h81, 1'b1, 2'b11, 1'b0);   // leave a word pending
    start(0);
    for (int i = 0; i < 5; i++) strobe(0, 1'b1);
    checks++;
    if (bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame: got %b expected 1", bz[0]);
    end
    @(negedge clk); rst = 1'b1; fs[0] = 1'b1;       // reset beats frame_start
    @(negedge clk); rst = 1'b0; fs[0] = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== 13'h0000) begin
        errors++;
        $display("FAIL reset_mid inst%0d: got %h expected %h", k, obs_vec(k), 13'h0000);
      end
    end
    for (int i = 0; i < 9; i++) strobe(0, 1'b1);
    checks++;
    if (obs_vec(0) !== 13'h0000) begin
      errors++;
      $display("FAIL idle_strobes: got %h expected %h", obs_vec(0), 13'h0000);
    end
    send_frame(0, 1'b1, 8'h5A, 1'b0, 2'b11, 1'b0);
    checks++;
    if (obs_vec(0) !== {8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_5a: got %h expected %h", obs_vec(0), {8'h5A, 5'b10000});
    end
    do_read(0);
  endtask

  task automatic test_random();
    int         k;
    int         mode;
    logic [7:0] d;
    logic       p;
    logic [1:0] s;
    for (int n = 0; n < 60; n++) begin
      k    = int'($urandom_range(0, 2));
      d    = 8'($urandom);
      p    = 1'($urandom);
      s    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      mode = int'($urandom_range(0, 3));
      if (mode == 1) do_read(k);
      if ($urandom_range(0, 4) == 0) begin
        start(k);
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) strobe(k, 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_frame(k, 1'b1, d, p, s, (mode == 2) ? 1'b1 : 1'b0);
      checks++;
      if (obs_vec(k) !== exp_vec(k, 1'b0)) begin
        errors++;
        $display("FAIL random%0d inst%0d: got %h expected %h", n, k, obs_vec(k), exp_vec(k, 1'b0));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      fs[k] = 1'b0; st[k] = 1'b0; si[k] = 1'b0; rd[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_defaults();
    test_parity();
    test_overrun();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_frame_rx.md
Name: sr_frame_rx

Overview:
Parametrised receive frame shift register, the successor to the fixed 9-bit receive shifter. It accepts serial bits on an external shift strobe and supports configurable data width, bit order, optional parity and one or two stop bits. It counts received bits, checks parity and framing, and holds the completed word in an output register with a valid/read handshake and overrun detection. It sits between the bit-timing/start-detect logic and the packet consumer.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..32).
PARITY_EN, 0, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits (1 or 2).
LSB_FIRST, 1, 1 = first received data bit goes to packet_data[0]; 0 = first received bit goes to packet_data[DATA_BITS-1].

Ports:
clk  input  1  system clock; all logic is clocked on the rising edge.
rst  input  1  synchronous, active-high reset.
frame_start  input  1  one-cycle pulse marking the start of a new frame; clears the bit counter.
shift_strobe  input  1  one-cycle pulse; sample serial_in.
serial_in  input  1  serial data bit.
data_read  input  1  consumer acknowledge; clears data_valid and overrun_error.
packet_data  output  DATA_BITS  last completed data word.
data_valid  output  1  level; a word is waiting in packet_data.
parity_error  output  1  parity mismatch on the word in packet_data.
framing_error  output  1  at least one stop bit of the word was 0.
overrun_error  output  1  sticky; a word was overwritten before it was read.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS. The bit counter is ceil(log2(FRAME_BITS+1)) bits wide.
- Reset: state = IDLE, counter = 0, shift register = 0. All outputs are 0. Reset overrides every other input in the same cycle.
- IDLE:
  - shift_strobe is ignored.
  - frame_start clears the counter and shift register, then moves to SHIFT.
- SHIFT:
  - On shift_strobe, serial_in is shifted in at the MSB (register shifts right) and the counter increments. After FRAME_BITS strobes, the first received bit sits at index 0.
  - A strobe that brings the counter to FRAME_BITS moves the state to LOAD.
  - frame_start aborts the frame: counter and shift register are cleared, state stays SHIFT, and no output changes. If frame_start and shift_strobe occur together, frame_start wins and the strobe is dropped.
- LOAD (exactly one cycle):
  - packet_data = sr[DATA_BITS-1:0], bit-reversed when LSB_FIRST=0.
  - parity_error = (XOR of data bits XOR parity bit) != PARITY_ODD. It is forced to 0 when PARITY_EN=0.
  - framing_error = 1 if any stop bit is 0. The word is still delivered.
  - data_valid is set to 1.
  - If data_valid was already 1 and data_read is not asserted this cycle, overrun_error is set and the new word overwrites the old one.
  - shift_strobe in LOAD is ignored; strobes are guaranteed at least 2 clk apart.
  - Next state is SHIFT (counter and shift register cleared) if frame_start is high, otherwise IDLE.
- Latency: outputs update on the clock edge ending the LOAD cycle, i.e. visible 2 cycles after the final strobe cycle.
- data_read:
  - When data_valid=1 and the state is not LOAD, data_read clears data_valid and overrun_error next cycle.
  - In the same cycle as LOAD, the load wins: data_valid stays 1, overrun is not set, and the previous overrun_error is cleared.
  - data_read while data_valid=0 has no effect.
- packet_data, parity_error and framing_error hold their values until the next LOAD or reset.

Test Plan:
1. Defaults. frame_start, then 9 strobes with serial_in 1,0,1,0,0,1,0,1,1 -> 2 cycles after the last strobe: packet_data=0xA5, data_valid=1, framing_error=0, parity_error=0, busy=0.
2. Defaults. Same frame but stop bit 0 -> packet_data=0xA5, data_valid=1, framing_error=1.
3. PARITY_EN=1, PARITY_ODD=0. Data 0x07 with parity 0 -> parity_error=1. Repeat with parity 1 -> parity_error=0. Separately, PARITY_ODD=1 with data 0x07 and parity 0 -> parity_error=0.
4. Overrun. Receive 0x11, then 0x22 with no data_read -> overrun_error=1, packet_data=0x22. Pulse data_read -> data_valid=0, overrun_error=0 next cycle. Also check data_read coinciding with LOAD -> data_valid=1, overrun_error=0.
5. Abort and bit order. frame_start, 4 strobes, frame_start, then a full 0x3C frame -> one data_valid, packet_data=0x3C. Repeat with LSB_FIRST=0 -> packet_data=0x3C (bit-reversed stimulus sent MSB first).
6. Reset mid-frame. rst after 5 strobes -> all outputs 0 and busy=0. Strobes are ignored until frame_start, after which a clean 0x5A frame delivers 0x5A.
